// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA unit: one bit of shift per clock over a working register,
// with a start/busy/done handshake matching the multdiv unit.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_r;

    // A request is accepted from IDLE or DONE, so back-to-back operations need no gap.
    // busy stays low for shamt==0: the single SHIFT cycle only moves work into result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            op_r   <= OP_SLL;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        work <= data_in;
                        cnt  <= shamt;
                        op_r <= op;
                        err  <= 1'b0;
                        if (op == OP_ILL) begin
                            result <= data_in;
                            err    <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            busy  <= (shamt != '0);
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        case (op_r)
                            OP_SLL:  work <= {work[WIDTH-2:0], 1'b0};
                            OP_SRL:  work <= {1'b0, work[WIDTH-1:1]};
                            OP_SRA:  work <= {work[WIDTH-1], work[WIDTH-1:1]};
                            default: work <= work;
                        endcase
                    end else begin
                        result <= work;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, hand-written corner
// sequences and randomized operations checked against a behavioural shift model.
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err;

    int testCount;
    int failCount;

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] expRes;
        logic        expErr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: the shift expressed directly with shift operators.
    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] d,
                                             input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Issues one request at the next edge, then waits for done. lat counts edges after E0.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                                 output int lat, output logic sawBusy, output logic stable);
        logic [31:0] prevRes;
        @(negedge clock);
        prevRes = result;
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
        @(posedge clock);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        data_in = $urandom;
        shamt   = 5'($urandom);
        lat     = 0;
        sawBusy = busy;
        stable  = 1'b1;
        while (!done && lat < 200) begin
            if (result !== prevRes) stable = 1'b0;
            @(posedge clock);
            #1;
            lat++;
            if (busy) sawBusy = 1'b1;
        end
    endtask

    task automatic runAndCheck(input string name, input logic [1:0] o, input logic [31:0] d,
                               input logic [4:0] s, input logic [31:0] expRes, input logic expErr);
        int   lat;
        logic sawBusy;
        logic stable;
        int   expLat;
        expLat = (o == 2'b11) ? 0 : int'(s) + 1;
        applyStimulus(o, d, s, lat, sawBusy, stable);
        checkOutput({name, " done"}, 32'(done), 32'd1);
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " result"}, result, expRes);
        checkOutput({name, " err"}, 32'(err), 32'(expErr));
        checkOutput({name, " busy seen"}, 32'(sawBusy), 32'(o != 2'b11 && s != 5'd0));
        checkOutput({name, " result stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        logic sawBusy;
        logic stable;
        logic [1:0]  rOp;
        logic [31:0] rData;
        logic [4:0]  rShamt;
        logic        sawDone;

        testCount = 0;
        failCount = 0;

        vecs[0] = '{2'b00, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
        vecs[1] = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        vecs[2] = '{2'b01, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
        vecs[3] = '{2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
        vecs[4] = '{2'b11, 32'h12345678, 5'd7,  32'h12345678, 1'b1};
        vecs[5] = '{2'b00, 32'h00000001, 5'd8,  32'h00000100, 1'b0};
        vecs[6] = '{2'b10, 32'h80000001, 5'd31, 32'hFFFFFFFF, 1'b0};
        vecs[7] = '{2'b10, 32'h7FFFFFF0, 5'd31, 32'h00000000, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;
        #2;
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt,
                        vecs[i].expRes, vecs[i].expErr);
        end

        // Start while busy is dropped; then a start in the DONE cycle is accepted.
        @(negedge clock);
        start = 1'b1; op = 2'b00; data_in = 32'h1; shamt = 5'd8;
        @(posedge clock); #1; start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = 2'b01; data_in = 32'hFFFFFFFF; shamt = 5'd1;
        @(posedge clock); #1; start = 1'b0;
        checkOutput("ignored start busy", 32'(busy), 32'd1);
        lat = 3;
        while (!done && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        checkOutput("ignored start latency", 32'(lat), 32'd9);
        checkOutput("ignored start result", result, 32'h00000100);
        runAndCheck("back-to-back", 2'b01, 32'h00000100, 5'd4, 32'h00000010, 1'b0);

        // Asynchronous reset in the middle of a shift.
        @(negedge clock);
        start = 1'b1; op = 2'b00; data_in = 32'h3; shamt = 5'd10;
        @(posedge clock); #1; start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        checkOutput("async reset err", 32'(err), 32'd0);
        checkOutput("async reset result", result, 32'h0);
        #2;
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("no done after reset", 32'(sawDone), 32'd0);

        // Illegal op sets err; the next legal request clears it.
        runAndCheck("illegal", 2'b11, 32'hCAFEF00D, 5'd3, 32'hCAFEF00D, 1'b1);
        runAndCheck("err cleared", 2'b00, 32'h0000000F, 5'd4, 32'h000000F0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rOp    = 2'($urandom_range(0, 3));
            rData  = $urandom;
            rShamt = 5'($urandom_range(0, 31));
            runAndCheck($sformatf("rand%0d", i), rOp, rData, rShamt,
                        refShift(rOp, rData, rShamt), rOp == 2'b11);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
                checkOutput($sformatf("rand%0d idle hold", i), result,
                            refShift(rOp, rData, rShamt));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
